sub_serial: RTL and testbench

//  Bit-serial unsigned subtractor: diff = a - b, one bit per clock, LSB first,

---
 rtl/sub_serial.sv | 108 ++++++++++
 tb/tb_sub_serial.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sub_serial.sv
// rtl/sub_serial.sv - bit-serial unsigned subtractor, LSB first, borrow held in a flop
module sub_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic             br;
    logic             br_next;
    logic             d;
    logic             last;
    logic [CW-1:0]    cnt;

    // One full-subtractor slice; the borrow is the only state carried between bits.
    assign d        = a_sr[0] ^ b_sr[0] ^ br;
    assign br_next  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    assign res_next = {d, res_sr[WIDTH-1:1]};
    assign last     = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SHIFT;
            SHIFT:   if (last)  next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            SHIFT:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        res_sr <= '0;
                        br     <= 1'b0;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    br     <= br_next;
                    cnt    <= cnt + 1'b1;
                    // Published outputs move only here, so they stay stable through IDLE.
                    if (last) begin
                        diff       <= res_next;
                        borrow_out <= br_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sub_serial.sv
// tb/tb_sub_serial.sv - scoreboard bench for sub_serial against an arithmetic reference
module tb_sub_serial;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    int checks = 0;
    int passes = 0;

    logic [WIDTH:0]   expq[$];
    logic [WIDTH-1:0] prev_diff = '0;
    logic             prev_bor  = 1'b0;

    sub_serial #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        int da;
        int db;
        int md;
        da = int'(av);
        db = int'(bv);
        md = (da - db + (1 << WIDTH)) % (1 << WIDTH);
        return {(da < db), WIDTH'(md)};
    endfunction

    always @(negedge clk) begin
        logic [WIDTH:0] e;
        if (!rst_n) begin
            prev_diff = '0;
            prev_bor  = 1'b0;
        end else if (done) begin
            if (expq.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = expq.pop_front();
                check("diff", 32'(diff), 32'(e[WIDTH-1:0]));
                check("borrow_out", 32'(borrow_out), 32'(e[WIDTH]));
            end
            prev_diff = diff;
            prev_bor  = borrow_out;
        end else begin
            check("diff_hold", 32'(diff), 32'(prev_diff));
            check("borrow_hold", 32'(borrow_out), 32'(prev_bor));
        end
    end

    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        int  busy_n;
        bit  seen;
        busy_n = 0;
        seen   = 0;
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        expq.push_back(model(av, bv));
        for (int k = 1; k <= WIDTH + 4 && !seen; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                a     = 8'($urandom);
                b     = 8'($urandom);
            end
            if (busy) busy_n++;
            if (done) begin
                seen = 1;
                check("latency", 32'(k), 32'(WIDTH + 1));
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        check("busy_cycles", 32'(busy_n), 32'(WIDTH));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow_out), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_diff", 32'(diff), 32'd0);

        run_op(8'd5, 8'd3);
        run_op(8'd3, 8'd5);
        run_op(8'd0, 8'd255);
        run_op(8'hA5, 8'hA5);
        run_op(8'd255, 8'd0);

        // A start pulse mid-operation must be ignored entirely.
        @(negedge clk);
        a = 8'h10; b = 8'h01; start = 1'b1;
        expq.push_back(model(8'h10, 8'h01));
        for (int k = 1; k <= WIDTH + 6; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 3) begin
                start = 1'b1; a = 8'h22; b = 8'h99;
            end
            if (k == 4) start = 1'b0;
            if (k == WIDTH + 1) check("midstart_done", 32'(done), 32'd1);
        end

        // start held high through DONE: the second op is accepted only from IDLE.
        @(negedge clk);
        a = 8'h40; b = 8'h41; start = 1'b1;
        expq.push_back(model(8'h40, 8'h41));
        expq.push_back(model(8'h40, 8'h41));
        for (int k = 1; k <= 2 * WIDTH + 4; k++) begin
            @(negedge clk);
            if (k == WIDTH + 1) check("held_done1", 32'(done), 32'd1);
            if (k == WIDTH + 2) begin
                check("held_idle_busy", 32'(busy), 32'd0);
                check("held_idle_done", 32'(done), 32'd0);
            end
            if (k == WIDTH + 3) begin
                check("held_restart_busy", 32'(busy), 32'd1);
                start = 1'b0;
            end
            if (k == 2 * WIDTH + 3) check("held_done2", 32'(done), 32'd1);
        end

        // Asynchronous reset during SHIFT discards the operation.
        @(negedge clk);
        a = 8'h77; b = 8'h11; start = 1'b1;
        expq.push_back(model(8'h77, 8'h11));
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_busy", 32'(busy), 32'd0);
        check("async_done", 32'(done), 32'd0);
        check("async_diff", 32'(diff), 32'd0);
        check("async_borrow", 32'(borrow_out), 32'd0);
        expq.delete();
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (WIDTH + 3) @(negedge clk);
        run_op(8'd200, 8'd100);

        repeat (256) run_op(8'($urandom), 8'($urandom));

        repeat (4) @(negedge clk);
        check("queue_empty", 32'(expq.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
